cache_req_initiator: RTL and testbench



---
 rtl/cache_req_initiator.sv | 115 +++++++++++
 tb/tb_cache_req_initiator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_initiator.sv
// cache_req_initiator: turns host commands into single-cycle tiny-cache requests,
// captures the registered hit/rdata after RESP_LAT cycles and keeps hit/miss stats.
module cache_req_initiator #(
   parameter int AW       = 2,
   parameter int DW       = 2,
   parameter int RESP_LAT = 1,
   parameter int CW       = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_rw,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_rw,
   output logic          rsp_hit,
   output logic [DW-1:0] rsp_rdata,
   output logic          req_valid,
   output logic          req_rw,
   output logic [AW-1:0] req_addr,
   output logic [DW-1:0] req_wdata,
   input  logic          cache_hit,
   input  logic [DW-1:0] cache_rdata,
   input  logic          clr_stats,
   output logic [CW-1:0] hit_cnt,
   output logic [CW-1:0] miss_cnt,
   output logic          busy
);
   localparam int LW = RESP_LAT > 1 ? $clog2(RESP_LAT) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
   state_e          state_q;
   logic            rw_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [LW-1:0]   cnt_q;
   logic            rsp_valid_q, rsp_rw_q, rsp_hit_q, busy_q;
   logic [DW-1:0]   rsp_rdata_q;
   logic [CW-1:0]   hit_q, miss_q;
   logic            issue, capture;
   assign issue   = state_q == ISSUE;
   assign capture = ena && state_q == WAIT && cnt_q == '0;
   // rst_n gates cmd_ready so every output reads 0 while reset is held
   assign cmd_ready = rst_n && ena && state_q == IDLE;
   assign req_valid = ena && issue;
   assign req_rw    = issue && rw_q;
   assign req_addr  = issue ? addr_q : '0;
   assign req_wdata = issue ? wdata_q : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rw    = rsp_rw_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = busy_q;
   assign hit_cnt   = hit_q;
   assign miss_cnt  = miss_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rw_q    <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_rdata_q <= '0;
         busy_q      <= 1'b0;
      end else if (ena) begin
         case (state_q)
            IDLE: if (cmd_valid) begin
               rw_q    <= cmd_rw;
               addr_q  <= cmd_addr;
               wdata_q <= cmd_wdata;
               busy_q  <= 1'b1;
               state_q <= ISSUE;
            end
            ISSUE: begin
               cnt_q   <= LW'(RESP_LAT - 1);
               state_q <= WAIT;
            end
            WAIT: if (cnt_q == '0) begin
               rsp_hit_q   <= cache_hit;
               rsp_rdata_q <= rw_q ? '0 : cache_rdata;
               rsp_rw_q    <= rw_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
            RESP: if (rsp_ready) begin
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   // clear works independently of ena and beats a same-edge increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (clr_stats) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (capture) begin
         if (cache_hit && hit_q != '1) hit_q <= hit_q + 1'b1;
         if (!cache_hit && miss_q != '1) miss_q <= miss_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_cache_req_initiator.sv
// tb_cache_req_initiator: random transactions on a RESP_LAT=1/CW=8 and a RESP_LAT=3/CW=2
// instance, each against a latency-pipelined cache model and a transaction-level scoreboard.
module tb_cache_req_initiator;
   logic       clk = 1'b0;
   logic       rst_n [2], ena [2], cmd_valid [2], cmd_rw [2], rsp_ready [2], clr_stats [2];
   logic [1:0] cmd_addr [2], cmd_wdata [2];
   logic       cmd_ready [2], rsp_valid [2], rsp_rw [2], rsp_hit [2];
   logic       req_valid [2], req_rw [2], busy [2], cache_hit [2];
   logic [1:0] rsp_rdata [2], req_addr [2], req_wdata [2], cache_rdata [2];
   logic [7:0] hit_cnt0, miss_cnt0;
   logic [1:0] hit_cnt1, miss_cnt1;
   bit         cv [2][4];
   bit   [1:0] cd [2][4];
   bit         pipe_h [2][4];
   bit   [1:0] pipe_d [2][4];
   int         hc [2], mc [2];
   int         errors = 0, checks = 0;

   always #5 clk = ~clk;

   cache_req_initiator #(.AW(2), .DW(2), .RESP_LAT(1), .CW(8)) u0 (
      .clk(clk), .rst_n(rst_n[0]), .ena(ena[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_rw(cmd_rw[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]), .rsp_valid(rsp_valid[0]),
      .rsp_ready(rsp_ready[0]), .rsp_rw(rsp_rw[0]), .rsp_hit(rsp_hit[0]), .rsp_rdata(rsp_rdata[0]),
      .req_valid(req_valid[0]), .req_rw(req_rw[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .cache_hit(cache_hit[0]), .cache_rdata(cache_rdata[0]), .clr_stats(clr_stats[0]),
      .hit_cnt(hit_cnt0), .miss_cnt(miss_cnt0), .busy(busy[0]));

   cache_req_initiator #(.AW(2), .DW(2), .RESP_LAT(3), .CW(2)) u1 (
      .clk(clk), .rst_n(rst_n[1]), .ena(ena[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_rw(cmd_rw[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]), .rsp_valid(rsp_valid[1]),
      .rsp_ready(rsp_ready[1]), .rsp_rw(rsp_rw[1]), .rsp_hit(rsp_hit[1]), .rsp_rdata(rsp_rdata[1]),
      .req_valid(req_valid[1]), .req_rw(req_rw[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .cache_hit(cache_hit[1]), .cache_rdata(cache_rdata[1]), .clr_stats(clr_stats[1]),
      .hit_cnt(hit_cnt1), .miss_cnt(miss_cnt1), .busy(busy[1]));

   // cache model: result of a request appears RESP_LAT edges after the request edge; other slots are noise
   assign cache_hit[0]   = pipe_h[0][0];
   assign cache_rdata[0] = pipe_d[0][0];
   assign cache_hit[1]   = pipe_h[1][2];
   assign cache_rdata[1] = pipe_d[1][2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         for (int s = 3; s > 0; s--) begin
            pipe_h[k][s] <= pipe_h[k][s-1];
            pipe_d[k][s] <= pipe_d[k][s-1];
         end
         if (req_valid[k]) begin
            pipe_h[k][0] <= cv[k][req_addr[k]];
            pipe_d[k][0] <= cd[k][req_addr[k]];
            if (req_rw[k]) begin
               cv[k][req_addr[k]] <= 1'b1;
               cd[k][req_addr[k]] <= req_wdata[k];
            end
         end else begin
            pipe_h[k][0] <= 1'($urandom);
            pipe_d[k][0] <= 2'($urandom);
         end
      end
   end

   function automatic int lat(input int k);
      return k ? 3 : 1;
   endfunction

   function automatic int sat(input int k);
      return k ? 3 : 255;
   endfunction

   function automatic int hcnt(input int k);
      return k ? int'(hit_cnt1) : int'(hit_cnt0);
   endfunction

   function automatic int mcnt(input int k);
      return k ? int'(miss_cnt1) : int'(miss_cnt0);
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic txn(input int k, input bit rw, input bit [1:0] a, input bit [1:0] d,
                      input int hold, input int drop, input bit clr);
      bit       eh;
      bit [1:0] er;
      int       n, nreq;
      bit       got;
      eh = cv[k][a];
      er = rw ? 2'd0 : cd[k][a];
      @(negedge clk);
      cmd_valid[k] = 1'b1;
      cmd_rw[k]    = rw;
      cmd_addr[k]  = a;
      cmd_wdata[k] = d;
      #1;
      check("cmd_ready_idle", cmd_ready[k], 1);
      check("busy_idle", busy[k], 0);
      @(posedge clk);
      #1;
      cmd_valid[k] = 1'b0;
      cmd_rw[k]    = 1'($urandom);
      cmd_addr[k]  = 2'($urandom);
      cmd_wdata[k] = 2'($urandom);
      n = 0;
      nreq = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         ena[k] = n > drop;
         clr_stats[k] = clr && n == lat(k) + 1 + drop;
         #1;
         if (req_valid[k]) begin
            nreq++;
            check("req_cycle", n, drop + 1);
            check("req_rw", req_rw[k], int'(rw));
            check("req_addr", req_addr[k], int'(a));
            check("req_wdata", req_wdata[k], int'(d));
         end else if (n > drop + 1) begin
            check("req_fields_zero", {req_rw[k], req_addr[k], req_wdata[k]}, 0);
         end
         check("cmd_ready_busy", cmd_ready[k], 0);
         check("busy_txn", busy[k], 1);
         got = rsp_valid[k];
      end
      clr_stats[k] = 1'b0;
      check("rsp_latency", n, lat(k) + 2 + drop);
      check("req_pulses", nreq, 1);
      if (clr) begin
         hc[k] = 0;
         mc[k] = 0;
      end else if (eh) begin
         hc[k] = hc[k] < sat(k) ? hc[k] + 1 : hc[k];
      end else begin
         mc[k] = mc[k] < sat(k) ? mc[k] + 1 : mc[k];
      end
      check("rsp_hit", rsp_hit[k], int'(eh));
      check("rsp_rdata", rsp_rdata[k], int'(er));
      check("rsp_rw", rsp_rw[k], int'(rw));
      check("hit_cnt", hcnt(k), hc[k]);
      check("miss_cnt", mcnt(k), mc[k]);
      for (int h = 0; h < hold; h++) begin
         if ($urandom_range(1) == 1) begin
            rsp_ready[k] = 1'b0;
            ena[k] = 1'b1;
         end else begin
            rsp_ready[k] = 1'b1;
            ena[k] = 1'b0;
         end
         @(negedge clk);
         #1;
         check("hold_valid", rsp_valid[k], 1);
         check("hold_hit", rsp_hit[k], int'(eh));
         check("hold_rdata", rsp_rdata[k], int'(er));
         check("hold_rw", rsp_rw[k], int'(rw));
         check("hold_cmd_ready", cmd_ready[k], 0);
      end
      rsp_ready[k] = 1'b1;
      ena[k] = 1'b1;
      @(negedge clk);
      rsp_ready[k] = 1'b0;
      #1;
      check("rsp_done", rsp_valid[k], 0);
      check("busy_done", busy[k], 0);
      check("cmd_ready_back", cmd_ready[k], 1);
   endtask

   task automatic check_reset_outputs(input int k);
      check("rst_cmd_ready", cmd_ready[k], 0);
      check("rst_rsp", {rsp_valid[k], rsp_rw[k], rsp_hit[k], rsp_rdata[k]}, 0);
      check("rst_req", {req_valid[k], req_rw[k], req_addr[k], req_wdata[k]}, 0);
      check("rst_cnts", hcnt(k) + mcnt(k), 0);
      check("rst_busy", busy[k], 0);
   endtask

   task automatic rst_mid(input int k);
      @(negedge clk);
      cmd_valid[k] = 1'b1;
      cmd_rw[k]    = 1'b0;
      cmd_addr[k]  = 2'($urandom);
      @(posedge clk);
      #1;
      cmd_valid[k] = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("busy_wait", busy[k], 1);
      rst_n[k] = 1'b0;
      #1;
      check_reset_outputs(k);
      hc[k] = 0;
      mc[k] = 0;
      @(negedge clk);
      rst_n[k] = 1'b1;
      repeat (6) begin
         @(negedge clk);
         #1;
         check("post_rst_rsp", rsp_valid[k], 0);
         check("post_rst_busy", busy[k], 0);
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst_n[k] = 1'b0;
         ena[k] = 1'b1;
         cmd_valid[k] = 1'b0;
         cmd_rw[k] = 1'b0;
         cmd_addr[k] = 2'd0;
         cmd_wdata[k] = 2'd0;
         rsp_ready[k] = 1'b0;
         clr_stats[k] = 1'b0;
         hc[k] = 0;
         mc[k] = 0;
      end
      repeat (2) @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) check_reset_outputs(k);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      txn(0, 1'b1, 2'd2, 2'd3, 0, 0, 1'b0);
      txn(0, 1'b0, 2'd2, 2'd0, 0, 0, 1'b0);
      txn(0, 1'b0, 2'd2, 2'd0, 5, 0, 1'b0);
      txn(0, 1'b0, 2'd1, 2'd0, 0, 2, 1'b0);
      for (int i = 0; i < 25; i++)
         txn(0, 1'($urandom), 2'($urandom), 2'($urandom), $urandom_range(3), $urandom_range(2),
             $urandom_range(9) == 0);
      txn(1, 1'b1, 2'd1, 2'd2, 0, 0, 1'b0);
      for (int i = 0; i < 5; i++) txn(1, 1'b0, 2'd1, 2'd0, 0, 0, 1'b0);
      check("hit_saturated", hcnt(1), 3);
      txn(1, 1'b0, 2'd1, 2'd0, 0, 0, 1'b1);
      for (int i = 0; i < 15; i++)
         txn(1, 1'($urandom), 2'($urandom), 2'($urandom), $urandom_range(3), $urandom_range(2),
             $urandom_range(9) == 0);
      rst_mid(0);
      rst_mid(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
